// File: rtl/led_frame_writer.sv
// led_frame_writer: after the driver configuration wait, pulses a frame-start flag
// and streams one frame of per-LED brightness words from a selectable pattern engine.
//
// state  | meaning
// ST_CFG | driver register-configuration window; outputs idle
// ST_RUN | periodic frames: start flag, write burst, frame_done pulse
module led_frame_writer #(
    parameter int NUM_LEDS     = 360,
    parameter int NUM_ZONES    = 9,
    parameter int DATA_W       = 16,
    parameter int CFG_CYCLES   = 2500,
    parameter int FRAME_PERIOD = 420001,
    parameter int FLAG_LEN     = 29,
    parameter int WR_START     = 4,
    parameter int STRIPE       = 24,
    parameter int CHASE_DIV    = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [8*NUM_ZONES-1:0]        light_reg_flatted,
    input  logic [2:0]                    mode_selector,
    input  logic [7:0]                    gain,
    output logic                          cfg_done,
    output logic                          sdbpflag_wire,
    output logic                          wten_wire,
    output logic [$clog2(NUM_LEDS)-1:0]   wtaddr_wire,
    output logic [DATA_W-1:0]             wtdina_wire,
    output logic                          frame_done
);

    localparam int AW  = $clog2(NUM_LEDS);
    localparam int LPZ = NUM_LEDS / NUM_ZONES;
    localparam int ZW  = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
    localparam int LW  = (LPZ > 1) ? $clog2(LPZ) : 1;
    localparam int SW  = $clog2(STRIPE);
    localparam int FW  = $clog2(FRAME_PERIOD);
    localparam int CW  = (CFG_CYCLES > 1) ? $clog2(CFG_CYCLES) : 1;
    localparam int DVW = (CHASE_DIV > 1) ? $clog2(CHASE_DIV) : 1;

    // The frame timer counts down from FRAME_PERIOD-1; cycle j of a frame has
    // remaining count FRAME_PERIOD-1-j, so every window maps to a fixed range.
    localparam logic [FW-1:0] REM_TOP     = FW'(FRAME_PERIOD - 1);
    localparam logic [FW-1:0] REM_FLAG_HI = FW'(FRAME_PERIOD - 2);
    localparam logic [FW-1:0] REM_FLAG_LO = FW'(FRAME_PERIOD - 1 - FLAG_LEN);
    localparam logic [FW-1:0] REM_WR_HI   = FW'(FRAME_PERIOD - 1 - WR_START);
    localparam logic [FW-1:0] REM_WR_LO   = FW'(FRAME_PERIOD - WR_START - NUM_LEDS);
    localparam logic [FW-1:0] REM_DONE    = FW'(FRAME_PERIOD - 1 - WR_START - NUM_LEDS);

    typedef enum logic {ST_CFG, ST_RUN} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cfg_rem, cfg_rem_nxt;
    logic [FW-1:0]          frame_rem, frame_rem_nxt;
    logic                   frame_start, run_nxt, flag_d, burst_d, done_d;

    logic [2:0]             snap_mode;
    logic [8*NUM_ZONES-1:0] snap_light;
    logic [7:0]             snap_gain;

    logic [AW-1:0]          addr_cnt, chase_pos;
    logic [ZW-1:0]          zone_cnt;
    logic [LW-1:0]          lpz_cnt;
    logic [SW-1:0]          stripe_cnt;
    logic [DVW-1:0]         chase_div;

    logic [7:0]             bright;
    logic [15:0]            product;
    logic [DATA_W-1:0]      pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CFG;
            cfg_rem   <= CW'(CFG_CYCLES - 1);
            frame_rem <= '0;
        end else begin
            state     <= state_nxt;
            cfg_rem   <= cfg_rem_nxt;
            frame_rem <= frame_rem_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cfg_rem_nxt   = cfg_rem;
        frame_rem_nxt = frame_rem;
        frame_start   = 1'b0;
        case (state)
            ST_CFG: begin
                if (cfg_rem == '0) begin
                    state_nxt     = ST_RUN;
                    frame_start   = 1'b1;
                    frame_rem_nxt = REM_TOP;
                end else begin
                    cfg_rem_nxt = cfg_rem - 1'b1;
                end
            end
            ST_RUN: begin
                if (frame_rem == '0) begin
                    frame_start   = 1'b1;
                    frame_rem_nxt = REM_TOP;
                end else begin
                    frame_rem_nxt = frame_rem - 1'b1;
                end
            end
            default: state_nxt = ST_CFG;
        endcase
        run_nxt = (state_nxt == ST_RUN);
        flag_d  = run_nxt && (frame_rem_nxt >= REM_FLAG_LO) && (frame_rem_nxt <= REM_FLAG_HI);
        burst_d = run_nxt && (frame_rem_nxt >= REM_WR_LO) && (frame_rem_nxt <= REM_WR_HI);
        done_d  = run_nxt && (frame_rem_nxt == REM_DONE);
    end

    always_comb begin
        bright = '0;
        for (int z = 0; z < NUM_ZONES; z++) begin
            if (zone_cnt == ZW'(z)) bright = snap_light[8*z +: 8];
        end
        product = 16'(bright) * 16'(snap_gain);
        pix = '0;
        case (snap_mode)
            3'd0: pix = DATA_W'(product);
            3'd2: pix = (stripe_cnt < SW'(STRIPE/2)) ? '1 : '0;
            3'd3: begin
                if (stripe_cnt < SW'(STRIPE/3))        pix = '1;
                else if (stripe_cnt < SW'(2*STRIPE/3)) pix = DATA_W'(16'h0100);
                else                                   pix = '0;
            end
            3'd4: pix = (addr_cnt == chase_pos) ? '1 : '0;
            default: pix = '1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_done      <= 1'b0;
            sdbpflag_wire <= 1'b0;
            wten_wire     <= 1'b0;
            wtaddr_wire   <= '0;
            wtdina_wire   <= '0;
            frame_done    <= 1'b0;
            snap_mode     <= '0;
            snap_light    <= '0;
            snap_gain     <= '0;
            addr_cnt      <= '0;
            zone_cnt      <= '0;
            lpz_cnt       <= '0;
            stripe_cnt    <= '0;
            chase_pos     <= '0;
            chase_div     <= '0;
        end else begin
            cfg_done      <= run_nxt;
            sdbpflag_wire <= flag_d;
            wten_wire     <= burst_d;
            frame_done    <= done_d;
            wtaddr_wire   <= burst_d ? addr_cnt : '0;
            wtdina_wire   <= burst_d ? pix : '0;
            if (frame_start) begin
                snap_mode  <= mode_selector;
                snap_light <= light_reg_flatted;
                snap_gain  <= gain;
                addr_cnt   <= '0;
                zone_cnt   <= '0;
                lpz_cnt    <= '0;
                stripe_cnt <= '0;
                // Frame 0 only arms the divider; later frame starts step the chase.
                if (state == ST_CFG) begin
                    chase_div <= DVW'(CHASE_DIV - 1);
                end else if (chase_div == '0) begin
                    chase_div <= DVW'(CHASE_DIV - 1);
                    chase_pos <= (chase_pos == AW'(NUM_LEDS - 1)) ? '0 : chase_pos + 1'b1;
                end else begin
                    chase_div <= chase_div - 1'b1;
                end
            end else if (burst_d) begin
                addr_cnt   <= addr_cnt + 1'b1;
                stripe_cnt <= (stripe_cnt == SW'(STRIPE - 1)) ? '0 : stripe_cnt + 1'b1;
                if (lpz_cnt == LW'(LPZ - 1)) begin
                    lpz_cnt  <= '0;
                    zone_cnt <= zone_cnt + 1'b1;
                end else begin
                    lpz_cnt <= lpz_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_frame_writer.sv
// Directed bench for led_frame_writer: frame timing, pattern modes, chase, snapshot and reset.
module tb_led_frame_writer;

    localparam int N   = 48;
    localparam int NZ  = 4;
    localparam int CFG = 20;
    localparam int FP  = 100;
    localparam int FL  = 10;
    localparam int WR  = 4;
    localparam int ST  = 24;
    localparam int CD  = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] light_reg_flatted;
    logic [2:0]  mode_selector;
    logic [7:0]  gain;
    logic        cfg_done;
    logic        sdbpflag_wire;
    logic        wten_wire;
    logic [5:0]  wtaddr_wire;
    logic [15:0] wtdina_wire;
    logic        frame_done;

    led_frame_writer #(
        .NUM_LEDS(N), .NUM_ZONES(NZ), .DATA_W(16), .CFG_CYCLES(CFG),
        .FRAME_PERIOD(FP), .FLAG_LEN(FL), .WR_START(WR), .STRIPE(ST), .CHASE_DIV(CD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .light_reg_flatted(light_reg_flatted), .mode_selector(mode_selector), .gain(gain),
        .cfg_done(cfg_done), .sdbpflag_wire(sdbpflag_wire), .wten_wire(wten_wire),
        .wtaddr_wire(wtaddr_wire), .wtdina_wire(wtdina_wire), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          frame_k = 0;
    int          zones [NZ];
    int          g_gain = 0;
    logic [15:0] cap [N];
    int          chase_exp [6] = '{0, 0, 1, 1, 2, 2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h cycle=%0d frame=%0d", tag, obs, exp, cyc, frame_k);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_zones(input int z0, input int z1, input int z2, input int z3, input int g);
        zones[0] = z0; zones[1] = z1; zones[2] = z2; zones[3] = z3;
        g_gain = g;
        light_reg_flatted = {8'(z3), 8'(z2), 8'(z1), 8'(z0)};
        gain = 8'(g);
    endtask

    function automatic logic [15:0] exp_pix(input int m, input int a, input int cp);
        int s;
        s = a % ST;
        case (m)
            0: return 16'(zones[a / (N / NZ)] * g_gain);
            2: return (s < 12) ? 16'hFFFF : 16'h0000;
            3: return (s < 8) ? 16'hFFFF : ((s < 16) ? 16'h0100 : 16'h0000);
            4: return (a == cp) ? 16'hFFFF : 16'h0000;
            default: return 16'hFFFF;
        endcase
    endfunction

    // Entered at cycle F_k-1; leaves at cycle F_k+FP-1 with every cycle checked.
    task automatic check_frame(input int m, input int chg_j, input logic [2:0] chg_mode);
        int  cp;
        bit  ew;
        cp = (frame_k / CD) % N;
        for (int j = 0; j < FP; j++) begin
            tick();
            ew = (j >= WR) && (j < WR + N);
            chk("cfg_done", 32'(cfg_done), 32'd1);
            chk("sdbpflag", 32'(sdbpflag_wire), 32'((j >= 1) && (j <= FL)));
            chk("wten", 32'(wten_wire), 32'(ew));
            chk("wtaddr", 32'(wtaddr_wire), ew ? 32'(j - WR) : 32'd0);
            chk("wtdina", 32'(wtdina_wire), ew ? 32'(exp_pix(m, j - WR, cp)) : 32'd0);
            chk("frame_done", 32'(frame_done), 32'(j == WR + N));
            if (ew) cap[j - WR] = wtdina_wire;
            if (j == chg_j) mode_selector = chg_mode;
        end
        frame_k++;
    endtask

    task automatic check_lit(input string tag, input int exp_addr);
        int cnt;
        int at;
        cnt = 0;
        at = -1;
        for (int a = 0; a < N; a++) begin
            if (cap[a] == 16'hFFFF) begin
                cnt++;
                at = a;
            end
        end
        chk({tag, "_count"}, 32'(cnt), 32'd1);
        chk({tag, "_addr"}, 32'(at), 32'(exp_addr));
    endtask

    task automatic cfg_wait();
        for (int i = 1; i < CFG; i++) begin
            tick();
            chk("cfg_wait_idle",
                32'({cfg_done, sdbpflag_wire, wten_wire, frame_done, wtaddr_wire, wtdina_wire}), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mode_selector = 3'd4;
        set_zones(0, 0, 0, 0, 0);
        #12;
        chk("reset_idle",
            32'({cfg_done, sdbpflag_wire, wten_wire, frame_done, wtaddr_wire, wtdina_wire}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        cfg_wait();

        // chase from frame 0: lit address 0,0,1,1,2,2
        for (int k = 0; k < 6; k++) begin
            check_frame(4, -1, 3'd0);
            check_lit("chase", chase_exp[k]);
        end

        mode_selector = 3'd0;
        set_zones(10, 20, 30, 40, 2);
        check_frame(0, -1, 3'd0);
        chk("zone_a0", 32'(cap[0]), 32'd20);
        chk("zone_a11", 32'(cap[11]), 32'd20);
        chk("zone_a12", 32'(cap[12]), 32'd40);
        chk("zone_a23", 32'(cap[23]), 32'd40);
        chk("zone_a24", 32'(cap[24]), 32'd60);
        chk("zone_a35", 32'(cap[35]), 32'd60);
        chk("zone_a36", 32'(cap[36]), 32'd80);
        chk("zone_a47", 32'(cap[47]), 32'd80);

        set_zones(255, 255, 255, 255, 255);
        check_frame(0, -1, 3'd0);
        chk("zone_max_a0", 32'(cap[0]), 32'hFE01);
        chk("zone_max_a47", 32'(cap[47]), 32'hFE01);

        set_zones(10, 20, 30, 40, 0);
        check_frame(0, -1, 3'd0);
        chk("gain0_a5", 32'(cap[5]), 32'd0);
        chk("gain0_a40", 32'(cap[40]), 32'd0);

        mode_selector = 3'd3;
        check_frame(3, -1, 3'd0);
        chk("tri_a0", 32'(cap[0]), 32'hFFFF);
        chk("tri_a7", 32'(cap[7]), 32'hFFFF);
        chk("tri_a8", 32'(cap[8]), 32'h0100);
        chk("tri_a15", 32'(cap[15]), 32'h0100);
        chk("tri_a16", 32'(cap[16]), 32'h0000);
        chk("tri_a23", 32'(cap[23]), 32'h0000);
        chk("tri_a24", 32'(cap[24]), 32'hFFFF);
        chk("tri_a40", 32'(cap[40]), 32'h0000);

        mode_selector = 3'd2;
        check_frame(2, -1, 3'd0);
        chk("half_a11", 32'(cap[11]), 32'hFFFF);
        chk("half_a12", 32'(cap[12]), 32'h0000);
        chk("half_a24", 32'(cap[24]), 32'hFFFF);
        chk("half_a36", 32'(cap[36]), 32'h0000);

        // mode change mid-burst only takes effect on the next frame
        mode_selector = 3'd1;
        check_frame(1, 20, 3'd2);
        chk("snap_hold_a20", 32'(cap[20]), 32'hFFFF);
        chk("snap_hold_a47", 32'(cap[47]), 32'hFFFF);
        check_frame(2, -1, 3'd0);
        chk("snap_next_a12", 32'(cap[12]), 32'h0000);

        for (int m = 5; m < 8; m++) begin
            mode_selector = 3'(m);
            check_frame(m, -1, 3'd0);
            chk("mode_hi_a30", 32'(cap[30]), 32'hFFFF);
        end

        // chase keeps advancing through the other modes; run on to the wrap
        mode_selector = 3'd4;
        while (frame_k < 98) begin
            check_frame(4, -1, 3'd0);
            if (frame_k == 96) check_lit("chase_last", 47);
            if (frame_k == 97) check_lit("chase_wrap", 0);
        end

        // reset mid-burst
        mode_selector = 3'd1;
        for (int j = 0; j <= 30; j++) tick();
        chk("pre_rst_wten", 32'(wten_wire), 32'd1);
        chk("pre_rst_addr", 32'(wtaddr_wire), 32'd26);
        rst_n = 1'b0;
        #1;
        chk("async_rst_idle",
            32'({cfg_done, sdbpflag_wire, wten_wire, frame_done, wtaddr_wire, wtdina_wire}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        frame_k = 0;
        mode_selector = 3'd4;
        cfg_wait();
        check_frame(4, -1, 3'd0);
        check_lit("chase_after_rst", 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
